// File: rtl/ram_lpm_if.sv
// User-side bus of the main-memory RAM: address/data/write-enable in,
// registered read data and initialiser status out.
interface ram_lpm_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 5
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data;
    logic                  wren;
    logic [DATA_WIDTH-1:0] q;
    logic                  init_busy;

    modport master (output address, data, wren, input q, init_busy);
    modport slave  (input address, data, wren, output q, init_busy);
endinterface

// File: rtl/ram_lpm.sv
// Single-port synchronous RAM with registered read and a post-reset
// initialiser that writes mem[a] = a (low bits) to every word.
module ram_lpm #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 5
) (
    ram_lpm_if.slave bus,
    input  logic     Clock,
    input  logic     Resetn
);
    typedef enum logic {INIT, RUN} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] init_word;
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;

    generate
        if (DATA_WIDTH <= ADDR_WIDTH) begin : g_trunc
            assign init_word = ptr[DATA_WIDTH-1:0];
        end else begin : g_zext
            assign init_word = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, ptr};
        end
    endgenerate

    // Resetn gates the enable so a write on an edge during reset is dropped.
    always_comb begin
        mem_we    = Resetn && ((state == INIT) || bus.wren);
        mem_addr  = (state == INIT) ? ptr : bus.address;
        mem_wdata = (state == INIT) ? init_word : bus.data;
    end

    always_ff @(posedge Clock) begin
        if (mem_we)
            mem[mem_addr] <= mem_wdata;
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state         <= INIT;
            ptr           <= '0;
            bus.init_busy <= 1'b1;
            bus.q         <= '0;
        end else begin
            case (state)
                INIT: begin
                    ptr   <= ptr + ADDR_WIDTH'(1);
                    bus.q <= '0;
                    if (ptr == '1) begin
                        state         <= RUN;
                        bus.init_busy <= 1'b0;
                    end
                end
                RUN: begin
                    bus.q <= bus.wren ? bus.data : mem[bus.address];
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_lpm.sv
// Directed bench for ram_lpm: init timing/pattern, read/write, back-to-back,
// ignore-during-init and asynchronous mid-operation reset.
module tb_ram_lpm;
    localparam int AW = 7;
    localparam int DW = 5;

    logic Clock  = 1'b0;
    logic Resetn = 1'b0;
    int   n_chk  = 0;
    int   n_err  = 0;

    ram_lpm_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ram_lpm #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .bus    (bus.slave),
        .Clock  (Clock),
        .Resetn (Resetn)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic rd(input int a, input int exp, input string tag);
        bus.wren    = 1'b0;
        bus.address = AW'(a);
        tick();
        check(tag, int'(bus.q), exp);
    endtask

    task automatic wr(input int a, input int d, input string tag);
        bus.wren    = 1'b1;
        bus.address = AW'(a);
        bus.data    = DW'(d);
        tick();
        check(tag, int'(bus.q), d);
        bus.wren    = 1'b0;
    endtask

    // Runs from just after reset release until init_busy drops; returns edge count.
    task automatic wait_init(output int edges, output int q_nonzero, input bit poke);
        edges     = 0;
        q_nonzero = 0;
        do begin
            if (poke && edges == 10) begin
                bus.wren    = 1'b1;
                bus.address = AW'(3);
                bus.data    = DW'(31);
            end else begin
                bus.wren = 1'b0;
            end
            tick();
            edges++;
            if (bus.q !== '0) q_nonzero++;
        end while (bus.init_busy === 1'b1 && edges < 300);
        bus.wren = 1'b0;
    endtask

    initial begin
        int edges, qnz;
        bus.wren    = 1'b0;
        bus.address = '0;
        bus.data    = '0;

        tick();
        tick();
        check("reset_q", int'(bus.q), 0);
        check("reset_busy", int'(bus.init_busy), 1);

        Resetn = 1'b1;
        wait_init(edges, qnz, 1'b1);
        check("init_edges", edges, 128);
        check("init_q_zero", qnz, 0);
        check("init_busy_low", int'(bus.init_busy), 0);

        rd(0,   0,  "pat_0");
        rd(5,   5,  "pat_5");
        rd(31,  31, "pat_31");
        rd(32,  0,  "pat_32");
        rd(100, 4,  "pat_100");
        rd(127, 31, "pat_127");
        rd(3,   3,  "ignored_init_write");

        wr(100, 22, "wr100_rdw");
        rd(100, 22, "rd100");
        rd(101, 5,  "rd101_neigh");

        // q holds while address changes between edges
        bus.address = AW'(7);
        #3;
        check("q_hold", int'(bus.q), 5);

        wr(127, 9,  "wr127_rdw");
        wr(0,   17, "wr0_rdw");
        rd(127, 9,  "rd127");
        rd(0,   17, "rd0");

        wr(10, 1, "wr10_rdw");
        #2;
        Resetn = 1'b0;
        #1;
        check("midrst_q", int'(bus.q), 0);
        check("midrst_busy", int'(bus.init_busy), 1);
        bus.wren    = 1'b1;
        bus.address = AW'(10);
        bus.data    = DW'(1);
        tick();
        check("rst_edge_q", int'(bus.q), 0);
        bus.wren = 1'b0;
        #2;
        Resetn = 1'b1;
        wait_init(edges, qnz, 1'b0);
        check("reinit_edges", edges, 128);
        check("reinit_q_zero", qnz, 0);
        rd(10,  10, "reinit_10");
        rd(100, 4,  "reinit_100");
        rd(127, 31, "reinit_127");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
